// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures the period and high time of the 3.5x divided clock
// in the source clock domain. It checks for the alternating 3/4-cycle period
// pattern and reports lock status, error pulses and a saturating error count.
module clk_div_monitor #(
  parameter int unsigned PERIOD_LO = 3,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CYC_MAX = '1;
  localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] P_LO    = CNT_W'(PERIOD_LO);
  localparam logic [CNT_W-1:0] P_HI    = CNT_W'(PERIOD_LO + 1);
  localparam logic [CNT_W-1:0] T_OUT   = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    G_MAX   = GW'(LOCK_CNT);
  localparam logic [GW-1:0]    G_ONE   = GW'(1);
  localparam logic [ERR_W-1:0] E_MAX   = '1;
  localparam logic [ERR_W-1:0] E_ONE   = ERR_W'(1);

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

  state_t state, state_nx;

  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] hi;
  logic [GW-1:0]    good_cnt;
  logic             prev_good;
  logic             meas;
  logic             tmo;
  logic             good;
  logic             err_nx;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Two-flop synchronizer for the asynchronous divided clock plus an edge-detect delay flop
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= div_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Rise-to-rise cycle counter and high-time counter, both saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
      hi  <= '0;
    end else begin
      if (rise) begin
        cyc <= CYC_ONE;
      end else if (cyc != CYC_MAX) begin
        cyc <= cyc + CYC_ONE;
      end

      if (rise) begin
        hi <= CYC_ONE;
      end else if (s2 && (hi != CYC_MAX)) begin
        hi <= hi + CYC_ONE;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, measurement strobe, timeout and period classification
  always_comb begin
    state_nx = state;
    meas     = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = TRACK;
        end
      end
      TRACK: begin
        // A rise arriving in the same cycle as the timeout wins
        if (rise) begin
          meas = 1'b1;
        end else if (cyc == T_OUT) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Holding `period` as the previous measurement lets it double as the alternation reference
    good   = meas && ((cyc == P_LO) || (cyc == P_HI)) && (!prev_good || (cyc != period));
    err_nx = (meas && !good) || tmo;
  end

  // Measurement outputs, lock tracking and saturating error count
  always_ff @(posedge clk) begin
    if (rst) begin
      period     <= '0;
      high_cnt   <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      good_cnt   <= '0;
      prev_good  <= 1'b0;
    end else begin
      period_vld <= meas;
      err        <= err_nx;

      if (fall) begin
        high_cnt <= hi;
      end

      if (meas) begin
        period <= cyc;
      end

      if (good) begin
        prev_good <= 1'b1;
        if (good_cnt != G_MAX) begin
          good_cnt <= good_cnt + G_ONE;
        end
        if (good_cnt >= (G_MAX - G_ONE)) begin
          locked <= 1'b1;
        end
      end else if (err_nx) begin
        prev_good <= 1'b0;
        good_cnt  <= '0;
        locked    <= 1'b0;
      end

      if (err_nx && (err_cnt != E_MAX)) begin
        err_cnt <= err_cnt + E_ONE;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor: pulse-level stimulus drives a behavioural model
// that queues the expected measurement/error events; a negedge monitor pops and
// compares each event the DUT presents. A second instance with ERR_W=2 shares
// the stimulus to exercise error-counter saturation.
module tb_clk_div_monitor;

  localparam int TIMEOUT  = 16;
  localparam int LOCK_CNT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       div_in = 1'b0;

  logic [4:0] period, high_cnt;
  logic       period_vld, locked, err;
  logic [7:0] err_cnt;

  logic [4:0] period2, high_cnt2;
  logic       period_vld2, locked2, err2;
  logic [1:0] err_cnt2;

  clk_div_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .div_in    (div_in),
    .period    (period),
    .high_cnt  (high_cnt),
    .period_vld(period_vld),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  clk_div_monitor #(.ERR_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .div_in    (div_in),
    .period    (period2),
    .high_cnt  (high_cnt2),
    .period_vld(period_vld2),
    .locked    (locked2),
    .err       (err2),
    .err_cnt   (err_cnt2)
  );

  always #5 clk = ~clk;

  int cyc_tb = 0;
  always @(posedge clk) cyc_tb <= cyc_tb + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cyc;
    bit vld;
    int period;
    int high;
    bit err;
    bit locked;
    int errs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Reference model state (pulse level)
  bit m_track;
  bit m_prev_good;
  int m_last_p;
  int m_good;
  int m_errs;
  int prev_h, prev_l, last_rise;

  int last_p, rr, ph, hh, ll;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (tb cycle %0d)", name, act, exp, cyc_tb);
    end
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_track     = 1'b0;
    m_prev_good = 1'b0;
    m_last_p    = 0;
    m_good      = 0;
    m_errs      = 0;
  endtask

  task automatic measure(input int p, input int h, input int at);
    exp_t e;
    bit   g;
    g = ((p == 3) || (p == 4)) && (!m_prev_good || (p != m_last_p));
    if (g) begin
      m_prev_good = 1'b1;
      m_last_p    = p;
      if (m_good < LOCK_CNT) m_good++;
    end else begin
      m_prev_good = 1'b0;
      m_good      = 0;
      m_errs++;
    end
    e.cyc    = at;
    e.vld    = 1'b1;
    e.period = p;
    e.high   = h;
    e.err    = !g;
    e.locked = (m_good == LOCK_CNT);
    e.errs   = m_errs;
    q.push_back(e);
  endtask

  task automatic timeout_ev(input int at);
    exp_t e;
    m_track     = 1'b0;
    m_prev_good = 1'b0;
    m_good      = 0;
    m_errs++;
    e.cyc    = at;
    e.vld    = 1'b0;
    e.period = 0;
    e.high   = 0;
    e.err    = 1'b1;
    e.locked = 1'b0;
    e.errs   = m_errs;
    q.push_back(e);
  endtask

  // One divided-clock pulse: high h cycles, low l cycles, starting with a rise now
  task automatic pulse(input int h, input int l);
    if (m_track) measure(prev_h + prev_l, prev_h, cyc_tb + 3);
    else m_track = 1'b1;
    prev_h    = h;
    prev_l    = l;
    last_rise = cyc_tb;
    if (h + l > TIMEOUT) timeout_ev(cyc_tb + 3 + TIMEOUT);
    div_in = 1'b1;
    repeat (h) tick();
    div_in = 1'b0;
    repeat (l) tick();
  endtask

  // Extend the current low phase (stuck clock)
  task automatic hold_low(input int n);
    if (m_track && (prev_h + prev_l + n > TIMEOUT)) timeout_ev(last_rise + 3 + TIMEOUT);
    prev_l += n;
    div_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_zero();
    chk("rst_period",     int'(period),     0);
    chk("rst_high_cnt",   int'(high_cnt),   0);
    chk("rst_period_vld", int'(period_vld), 0);
    chk("rst_locked",     int'(locked),     0);
    chk("rst_err",        int'(err),        0);
    chk("rst_err_cnt",    int'(err_cnt),    0);
    chk("rst_err_cnt_w2", int'(err_cnt2),   0);
  endtask

  // Two-cycle reset; div_in is left as-is for the first reset cycle
  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_zero();
    chk("queue_empty_at_reset", q.size(), 0);
    q.delete();
    div_in = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic alt(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(2, 1);
      pulse(2, 2);
    end
    last_p = 4;
  endtask

  // Monitor: every DUT event must match the next queued expectation
  always @(negedge clk) begin
    if ((period_vld === 1'b1) || (err === 1'b1)) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got vld=%0b err=%0b at tb cycle %0d, required no event",
                 period_vld, err, cyc_tb);
      end else begin
        mon_e = q.pop_front();
        chk("event_cycle",   cyc_tb,            mon_e.cyc);
        chk("period_vld",    int'(period_vld),  int'(mon_e.vld));
        chk("period_vld_w2", int'(period_vld2), int'(mon_e.vld));
        if (mon_e.vld) begin
          chk("period",   int'(period),   mon_e.period);
          chk("high_cnt", int'(high_cnt), mon_e.high);
        end
        chk("err",        int'(err),      int'(mon_e.err));
        chk("locked",     int'(locked),   int'(mon_e.locked));
        chk("err_cnt",    int'(err_cnt),  sat(mon_e.errs, 255));
        chk("err_cnt_w2", int'(err_cnt2), sat(mon_e.errs, 3));
      end
    end
  end

  initial begin
    model_clear();
    last_p = 4;
    do_reset();

    // Nominal alternating 3/4 pattern
    alt(6);
    // Wrong ratio: constant 4, then relock
    repeat (3) pulse(2, 2);
    alt(5);
    // Out of range period of 5
    pulse(3, 2);
    alt(4);
    // Period exactly TIMEOUT (rise wins), then TIMEOUT+1 (timeout)
    pulse(8, 8);
    alt(3);
    pulse(8, 9);
    alt(4);
    // Stuck low after lock
    hold_low(30);
    alt(3);
    // More errors to push the narrow counter into saturation
    repeat (4) pulse(2, 2);

    // Randomised pulse train
    for (int i = 0; i < 150; i++) begin
      rr = $urandom_range(0, 99);
      if (rr < 75)      ph = (last_p == 3) ? 4 : 3;
      else if (rr < 95) ph = $urandom_range(2, 7);
      else              ph = $urandom_range(15, 19);
      hh = $urandom_range(1, ph - 1);
      ll = ph - hh;
      last_p = ph;
      pulse(hh, ll);
    end
    alt(3);

    // Reset while div_in is high, after the measurement of this rise is out
    if (m_track) measure(prev_h + prev_l, prev_h, cyc_tb + 3);
    div_in = 1'b1;
    repeat (3) tick();
    do_reset();

    // First rise after reset is not measured
    alt(4);
    hold_low(25);
    repeat (5) tick();
    chk("queue_empty_end", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
